hb_interp_sequencer: RTL and testbench
======================================

Name: hb_interp_sequencer

Overview:
Control-path sequencer for the 2x halfband interpolator datapath: owns the input/output ready/valid handshakes and issues the delay-line shift strobe and polyphase branch select. Each accepted input sample yields two output phases: phase 0 is the centre-tap branch, phase 1 is the FIR branch. Also supports a bypass mode (one output per input) and a flush command that drains the delay line with zero samples. Sits between the upstream sample source and the shared delay-line/branch-mux datapath.

Parameters:
DP_LATENCY, 2, cycles from io_dl_shift pulse to valid branch results at datapath output (0..15)
FLUSH_LEN, 8, zero samples injected per flush (1..255; normally taps/2)
CNT_W, 16, width of accepted-sample counter

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
io_in_valid  in  1  upstream sample valid
io_in_ready  out  1  sequencer accepts sample this cycle
io_bypass  in  1  config: 1 = no interpolation, phase 0 only; sampled at acceptance
io_flush  in  1  single-cycle request to drain delay line
io_dl_shift  out  1  one-cycle strobe: datapath delay line captures a new sample
io_dl_zero  out  1  with io_dl_shift: datapath shifts in zero instead of input data
io_phase  out  1  branch-mux select to datapath (0 = centre tap, 1 = FIR)
io_out_valid  out  1  datapath output (selected by io_phase) is valid
io_out_ready  in  1  downstream accepts output
io_busy  out  1  high in any state other than IDLE
io_sample_cnt  out  CNT_W  count of accepted input samples, wraps modulo 2^CNT_W

Behaviour:
- Reset (synchronous, any state): state=IDLE; io_in_ready=0 on the reset cycle, then 1 from the following cycle in IDLE; io_dl_shift=0, io_dl_zero=0, io_phase=0, io_out_valid=0, io_busy=0, io_sample_cnt=0; pending flush, bypass latch, and wait/flush counters cleared. Datapath contents are not cleared by this block.
- States: IDLE, WAIT, PH0, PH1, FLUSH.
- IDLE: io_in_ready=1.
  - If a flush is pending, it has priority: io_in_ready=0 and the sequencer enters FLUSH; flush_cnt=FLUSH_LEN.
  - Otherwise, in_valid & in_ready: io_dl_shift=1 combinationally in the same cycle; io_bypass is latched; io_sample_cnt increments; the sequencer goes to WAIT with wait_cnt=DP_LATENCY. If DP_LATENCY=0 it goes directly to PH0.
- WAIT: wait_cnt decrements each cycle; when it reaches 0, go to PH0. Outputs are low.
- PH0: io_phase=0, io_out_valid=1. Hold until io_out_ready.
  - On handshake with bypass latched: go to IDLE, or to FLUSH-continue when flushing.
  - On handshake otherwise: go to PH1.
- PH1: io_phase=1, io_out_valid=1. Hold until io_out_ready; then go to IDLE, or continue the flush.
- FLUSH (one-cycle issue state): io_dl_shift=1, io_dl_zero=1, flush_cnt decrements, then WAIT/PH0/PH1 as normal. After the final PH0/PH1 handshake, return to FLUSH if flush_cnt>0, else IDLE. Flush outputs always use interpolation (bypass latch is forced to 0). Flush samples do not increment io_sample_cnt.
- io_flush in IDLE with in_valid in the same cycle: flush wins; the sample is not accepted (io_in_ready=0 that cycle).
- io_flush in any non-IDLE state: sets flush_pending, which is honoured at the next IDLE. Repeated requests while pending, or while flushing, are absorbed (no queueing).
- io_out_valid and io_phase remain stable while io_out_ready=0 (no retraction).
- Throughput: one input every DP_LATENCY+3 cycles with io_out_ready held high (bypass: DP_LATENCY+2).
- Changes to io_bypass mid-sample have no effect until the next acceptance.

Decomposition:
- Shared package hb_interp_pkg:
  - state enum (IDLE/WAIT/PH0/PH1/FLUSH)
  - phase constants PHASE_CTAP=0, PHASE_FIR=1
  - latency/flush counter width localparams
- One natural sub-module: hb_down_counter (load, dec, zero flag), instantiated twice, for wait_cnt and flush_cnt.

Test Plan:
1. Reset, then one sample with DP_LATENCY=2, out_ready=1: io_dl_shift at cycle 0, out_valid with phase 0 at cycle 3, phase 1 at cycle 4, in_ready back at cycle 5; io_sample_cnt=1.
2. Backpressure: out_ready=0 for 5 cycles during PH0: out_valid=1 and phase=0 held stable, no extra io_dl_shift; release gives exactly 2 output handshakes.
3. Bypass=1, 4 back-to-back samples: exactly 4 outputs, all phase 0, no phase 1; io_sample_cnt=4.
4. Flush in IDLE with FLUSH_LEN=8: 8 io_dl_shift pulses, all with io_dl_zero=1, 16 outputs alternating phase 0/1; io_sample_cnt unchanged; io_busy low afterwards.
5. Flush during PH1, and flush+in_valid in the same IDLE cycle: flush executes after the current sample; the colliding sample is accepted only after the flush completes.
6. Reset asserted mid-WAIT and mid-FLUSH: next cycle state=IDLE, all outputs at reset values, pending flush dropped. CNT_W=4: the 16th accepted sample wraps io_sample_cnt to 0.

Source files
------------

// File: rtl/hb_interp_pkg.sv
// Shared types and constants for the halfband interpolator control path.
package hb_interp_pkg;

  localparam int unsigned LAT_W   = 4;  // covers DP_LATENCY 0..15
  localparam int unsigned FLUSH_W = 8;  // covers FLUSH_LEN 1..255

  localparam logic PHASE_CTAP = 1'b0;
  localparam logic PHASE_FIR  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PH0,
    ST_PH1,
    ST_FLUSH
  } seq_state_e;

endpackage

// File: rtl/hb_down_counter.sv
// Loadable down counter that saturates at zero and flags the zero count.
module hb_down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/hb_interp_sequencer.sv
// Handshake and strobe sequencer for the 2x halfband interpolator datapath:
// one delay-line shift per sample, then centre-tap and FIR output phases.
module hb_interp_sequencer
  import hb_interp_pkg::*;
#(
  parameter int unsigned DP_LATENCY = 2,
  parameter int unsigned FLUSH_LEN  = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic             io_bypass,
  input  logic             io_flush,
  output logic             io_dl_shift,
  output logic             io_dl_zero,
  output logic             io_phase,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic             io_busy,
  output logic [CNT_W-1:0] io_sample_cnt
);

  // WAIT exits when the counter is already zero, so it is loaded one short.
  localparam logic [LAT_W-1:0] WAIT_LOAD =
    (DP_LATENCY == 0) ? '0 : LAT_W'(DP_LATENCY - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_LEN);
  localparam seq_state_e ISSUE_NEXT = (DP_LATENCY == 0) ? ST_PH0 : ST_WAIT;

  seq_state_e state_q, state_d;
  logic       flush_pend_q, flush_pend_d;
  logic       flushing_q, flushing_d;
  logic       bypass_q, bypass_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic wait_load, wait_dec, wait_zero;
  logic flush_load, flush_dec, flush_zero;
  logic done;
  logic in_ready, dl_shift, dl_zero, phase, out_valid;

  hb_down_counter #(.W(LAT_W)) u_wait_cnt (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (wait_load),
    .load_val_i (WAIT_LOAD),
    .dec_i      (wait_dec),
    .zero_o     (wait_zero)
  );

  hb_down_counter #(.W(FLUSH_W)) u_flush_cnt (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (flush_load),
    .load_val_i (FLUSH_LOAD),
    .dec_i      (flush_dec),
    .zero_o     (flush_zero)
  );

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    flushing_d   = flushing_q;
    bypass_d     = bypass_q;
    cnt_d        = cnt_q;
    wait_load    = 1'b0;
    wait_dec     = 1'b0;
    flush_load   = 1'b0;
    flush_dec    = 1'b0;
    done         = 1'b0;
    in_ready     = 1'b0;
    dl_shift     = 1'b0;
    dl_zero      = 1'b0;
    phase        = PHASE_CTAP;
    out_valid    = 1'b0;

    // Requests while busy are remembered once; during a flush they are dropped.
    if (io_flush && (state_q != ST_IDLE) && !flushing_q) begin
      flush_pend_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (flush_pend_q || io_flush) begin
          flush_pend_d = 1'b0;
          flushing_d   = 1'b1;
          bypass_d     = 1'b0;
          flush_load   = 1'b1;
          state_d      = ST_FLUSH;
        end else begin
          in_ready = 1'b1;
          if (io_in_valid) begin
            dl_shift  = 1'b1;
            bypass_d  = io_bypass;
            cnt_d     = cnt_q + 1'b1;
            wait_load = 1'b1;
            state_d   = ISSUE_NEXT;
          end
        end
      end
      ST_WAIT: begin
        wait_dec = 1'b1;
        if (wait_zero) state_d = ST_PH0;
      end
      ST_PH0: begin
        out_valid = 1'b1;
        if (io_out_ready) begin
          if (bypass_q) done = 1'b1;
          else          state_d = ST_PH1;
        end
      end
      ST_PH1: begin
        phase     = PHASE_FIR;
        out_valid = 1'b1;
        if (io_out_ready) done = 1'b1;
      end
      ST_FLUSH: begin
        dl_shift  = 1'b1;
        dl_zero   = 1'b1;
        flush_dec = 1'b1;
        wait_load = 1'b1;
        state_d   = ISSUE_NEXT;
      end
      default: state_d = ST_IDLE;
    endcase

    if (done) begin
      if (flushing_q && !flush_zero) begin
        state_d = ST_FLUSH;
      end else begin
        state_d    = ST_IDLE;
        flushing_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      flush_pend_q <= 1'b0;
      flushing_q   <= 1'b0;
      bypass_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      flushing_q   <= flushing_d;
      bypass_q     <= bypass_d;
      cnt_q        <= cnt_d;
    end
  end

  // Outputs are forced to their idle values during the reset cycle itself.
  assign io_in_ready   = in_ready  & ~reset;
  assign io_dl_shift   = dl_shift  & ~reset;
  assign io_dl_zero    = dl_zero   & ~reset;
  assign io_phase      = phase     & ~reset;
  assign io_out_valid  = out_valid & ~reset;
  assign io_busy       = (state_q != ST_IDLE) & ~reset;
  assign io_sample_cnt = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_hb_interp_sequencer.sv
// Self-checking bench for hb_interp_sequencer: directed scenarios plus a
// randomized run scored against a transaction-level model.
module tb_hb_interp_sequencer;

  localparam int unsigned DPL = 2;
  localparam int unsigned FL  = 8;
  localparam int unsigned CW  = 4;
  localparam int unsigned CNT_MOD = 1 << CW;

  logic clock = 1'b0;
  logic reset, rst_next;
  logic in_valid, in_ready, bypass, flush;
  logic dl_shift, dl_zero, phase, out_valid, out_ready, busy;
  logic [CW-1:0] sample_cnt;

  int checks = 0;
  int errors = 0;
  int unsigned exp_cnt = 0;

  always #5 clock = ~clock;

  hb_interp_sequencer #(
    .DP_LATENCY (DPL),
    .FLUSH_LEN  (FL),
    .CNT_W      (CW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .io_in_valid   (in_valid),
    .io_in_ready   (in_ready),
    .io_bypass     (bypass),
    .io_flush      (flush),
    .io_dl_shift   (dl_shift),
    .io_dl_zero    (dl_zero),
    .io_phase      (phase),
    .io_out_valid  (out_valid),
    .io_out_ready  (out_ready),
    .io_busy       (busy),
    .io_sample_cnt (sample_cnt)
  );

  // Drive one cycle's inputs just after the falling edge, observe 1 ns later.
  task automatic step(input logic v, input logic b, input logic f, input logic r);
    @(negedge clock);
    reset = rst_next; in_valid = v; bypass = b; flush = f; out_ready = r;
    #1;
  endtask

  function automatic void bump_cnt();
    exp_cnt = (exp_cnt + 1) % CNT_MOD;
  endfunction

  task automatic test_reset();
    rst_next = 1'b1;
    step(1, 0, 1, 1);
    step(1, 0, 1, 1);
    checks++;
    if ({in_ready, dl_shift, dl_zero, out_valid, busy, phase} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {in_ready, dl_shift, dl_zero, out_valid, busy, phase});
    end
    rst_next = 1'b0;
    step(0, 0, 0, 1);
    exp_cnt = 0;
    checks++;
    if ({in_ready, busy, out_valid, sample_cnt} !== {3'b100, CW'(0)}) begin
      errors++;
      $display("FAIL reset_idle: got rdy=%b busy=%b vld=%b cnt=%0d expected rdy=1 busy=0 vld=0 cnt=0",
               in_ready, busy, out_valid, sample_cnt);
    end
  endtask

  task automatic test_single();
    step(1, 0, 0, 1);
    checks++;
    if ({in_ready, dl_shift, dl_zero} !== 3'b110) begin
      errors++;
      $display("FAIL single_accept: got rdy/shift/zero=%b expected 110", {in_ready, dl_shift, dl_zero});
    end
    bump_cnt();
    for (int unsigned i = 0; i < DPL; i++) begin
      step(0, 0, 0, 1);
      checks++;
      if ({out_valid, in_ready, busy, dl_shift} !== 4'b0010) begin
        errors++;
        $display("FAIL single_wait%0d: got vld/rdy/busy/shift=%b expected 0010", i, {out_valid, in_ready, busy, dl_shift});
      end
    end
    step(0, 0, 0, 1);
    checks++;
    if ({out_valid, phase} !== 2'b10) begin
      errors++;
      $display("FAIL single_ph0: got vld/phase=%b expected 10", {out_valid, phase});
    end
    step(0, 0, 0, 1);
    checks++;
    if ({out_valid, phase} !== 2'b11) begin
      errors++;
      $display("FAIL single_ph1: got vld/phase=%b expected 11", {out_valid, phase});
    end
    step(0, 0, 0, 1);
    checks++;
    if ({in_ready, busy, out_valid, sample_cnt} !== {3'b100, CW'(exp_cnt)}) begin
      errors++;
      $display("FAIL single_done: got rdy=%b busy=%b vld=%b cnt=%0d expected rdy=1 busy=0 vld=0 cnt=%0d",
               in_ready, busy, out_valid, sample_cnt, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    int shifts = 0;
    int hold_bad = 0;
    int hs = 0;
    logic [1:0] phases = 2'b00;
    step(1, 0, 0, 0);
    bump_cnt();
    for (int unsigned i = 0; i < DPL; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      if (dl_shift) shifts++;
      if ({out_valid, phase} !== 2'b10) hold_bad++;
    end
    checks++;
    if (hold_bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d unstable cycles expected 0", hold_bad);
    end
    checks++;
    if (shifts != 0) begin
      errors++;
      $display("FAIL bp_no_shift: got %0d shifts expected 0", shifts);
    end
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1);
      if (out_valid) begin
        if (hs < 2) phases[hs] = phase;
        hs++;
      end
    end
    checks++;
    if (hs != 2 || phases !== 2'b10) begin
      errors++;
      $display("FAIL bp_release: got %0d handshakes phases=%b expected 2 phases=10", hs, phases);
    end
  endtask

  task automatic test_bypass();
    int acc = 0;
    int outs = 0;
    int bad = 0;
    int gap_bad = 0;
    int last_acc = -1;
    for (int i = 0; i < 80; i++) begin
      step(acc < 4, 1, 0, 1);
      if (in_valid && in_ready) begin
        if (last_acc >= 0 && (i - last_acc) != int'(DPL + 2)) gap_bad++;
        last_acc = i;
        acc++;
        bump_cnt();
      end else if (acc == 4 && !busy) begin
        break;
      end
      if (out_valid) begin
        outs++;
        if (phase !== 1'b0) bad++;
      end
    end
    checks++;
    if (acc != 4 || outs != 4 || bad != 0) begin
      errors++;
      $display("FAIL bypass_outputs: got acc=%0d outs=%0d phase1=%0d expected 4 4 0", acc, outs, bad);
    end
    checks++;
    if (gap_bad != 0) begin
      errors++;
      $display("FAIL bypass_rate: got %0d bad gaps expected 0", gap_bad);
    end
    checks++;
    if (sample_cnt !== CW'(exp_cnt)) begin
      errors++;
      $display("FAIL bypass_cnt: got %0d expected %0d", sample_cnt, exp_cnt);
    end
  endtask

  task automatic test_flush_idle();
    int shifts = 0;
    int nonzero = 0;
    int outs = 0;
    int ph_bad = 0;
    bit ended = 0;
    step(1, 0, 1, 1);
    checks++;
    if ({in_ready, dl_shift} !== 2'b00) begin
      errors++;
      $display("FAIL flush_wins: got rdy/shift=%b expected 00", {in_ready, dl_shift});
    end
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 0, 1);
      if (dl_shift) begin
        shifts++;
        if (!dl_zero) nonzero++;
      end
      if (out_valid) begin
        if (phase !== outs[0]) ph_bad++;
        outs++;
      end
      if (!busy && in_ready) begin ended = 1; break; end
    end
    checks++;
    if (!ended || shifts != int'(FL) || nonzero != 0) begin
      errors++;
      $display("FAIL flush_shifts: got ended=%0d shifts=%0d nonzero=%0d expected 1 %0d 0", ended, shifts, nonzero, FL);
    end
    checks++;
    if (outs != int'(2 * FL) || ph_bad != 0) begin
      errors++;
      $display("FAIL flush_outputs: got outs=%0d bad_phase=%0d expected %0d 0", outs, ph_bad, 2 * FL);
    end
    checks++;
    if (sample_cnt !== CW'(exp_cnt) || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: got cnt=%0d busy=%b expected cnt=%0d busy=0", sample_cnt, busy, exp_cnt);
    end
  endtask

  task automatic test_flush_collide();
    int hs = 0;
    int hs_before = 0;
    int zsh = 0;
    int zbefore = 0;
    bit seen_zero = 0;
    bit accepted = 0;
    bit ended = 0;
    // Part A: flush requested while the current sample sits in its FIR phase.
    step(1, 0, 0, 0);
    bump_cnt();
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0);
      if (out_valid) break;
    end
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    checks++;
    if ({out_valid, phase} !== 2'b11) begin
      errors++;
      $display("FAIL collide_ph1: got vld/phase=%b expected 11", {out_valid, phase});
    end
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 0, 1);
      if (dl_shift && dl_zero) begin seen_zero = 1; zsh++; end
      if (out_valid) begin
        hs++;
        if (!seen_zero) hs_before++;
      end
      if (!busy && in_ready) begin ended = 1; break; end
    end
    checks++;
    if (!ended || hs_before != 1 || zsh != int'(FL) || hs != int'(1 + 2 * FL)) begin
      errors++;
      $display("FAIL collide_busy_flush: got ended=%0d before=%0d zero=%0d hs=%0d expected 1 1 %0d %0d",
               ended, hs_before, zsh, hs, FL, 1 + 2 * FL);
    end
    // Part B: flush and a valid sample arrive together in IDLE.
    hs = 0; zsh = 0; ended = 0;
    step(1, 0, 1, 1);
    checks++;
    if ({in_ready, dl_shift} !== 2'b00) begin
      errors++;
      $display("FAIL collide_idle_rdy: got rdy/shift=%b expected 00", {in_ready, dl_shift});
    end
    for (int i = 0; i < 300; i++) begin
      step(!accepted, 0, 0, 1);
      if (in_valid && in_ready) begin
        accepted = 1;
        zbefore = zsh;
        bump_cnt();
      end else if (accepted && !busy) begin
        ended = 1;
        break;
      end
      if (dl_shift && dl_zero) zsh++;
      if (out_valid) hs++;
    end
    checks++;
    if (!ended || !accepted || zbefore != int'(FL) || hs != int'(2 * FL + 2)) begin
      errors++;
      $display("FAIL collide_idle_order: got ended=%0d acc=%0d zero_before=%0d outs=%0d expected 1 1 %0d %0d",
               ended, accepted, zbefore, hs, FL, 2 * FL + 2);
    end
  endtask

  task automatic test_reset_mid();
    int shifts = 0;
    step(1, 0, 0, 1);
    step(0, 0, 1, 1);
    rst_next = 1'b1;
    step(0, 0, 0, 1);
    checks++;
    if ({in_ready, dl_shift, out_valid, busy} !== 4'b0) begin
      errors++;
      $display("FAIL rst_wait_cycle: got %b expected 0000", {in_ready, dl_shift, out_valid, busy});
    end
    rst_next = 1'b0;
    exp_cnt = 0;
    step(0, 0, 0, 1);
    checks++;
    if ({in_ready, busy, out_valid, sample_cnt} !== {3'b100, CW'(0)}) begin
      errors++;
      $display("FAIL rst_wait_after: got rdy=%b busy=%b vld=%b cnt=%0d expected 1 0 0 0",
               in_ready, busy, out_valid, sample_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 1);
      if (dl_shift) shifts++;
    end
    checks++;
    if (shifts != 0) begin
      errors++;
      $display("FAIL rst_pending_dropped: got %0d shifts expected 0", shifts);
    end
    step(0, 0, 1, 1);
    rst_next = 1'b1;
    step(0, 0, 0, 1);
    checks++;
    if ({dl_shift, dl_zero, busy, in_ready} !== 4'b0) begin
      errors++;
      $display("FAIL rst_flush_cycle: got %b expected 0000", {dl_shift, dl_zero, busy, in_ready});
    end
    rst_next = 1'b0;
    shifts = 0;
    step(0, 0, 0, 1);
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL rst_flush_after: got rdy/busy=%b expected 10", {in_ready, busy});
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 1);
      if (dl_shift) shifts++;
    end
    checks++;
    if (shifts != 0) begin
      errors++;
      $display("FAIL rst_flush_stopped: got %0d shifts expected 0", shifts);
    end
  endtask

  task automatic test_wrap();
    int acc = 0;
    int cnt_bad = 0;
    for (int i = 0; i < 200; i++) begin
      step(acc < 16, 1, 0, 1);
      if (sample_cnt !== CW'(exp_cnt)) cnt_bad++;
      if (in_valid && in_ready) begin
        acc++;
        bump_cnt();
      end else if (acc == 16 && !busy) begin
        break;
      end
    end
    checks++;
    if (acc != 16 || cnt_bad != 0) begin
      errors++;
      $display("FAIL wrap_track: got acc=%0d bad=%0d expected 16 0", acc, cnt_bad);
    end
    checks++;
    if (sample_cnt !== CW'(0)) begin
      errors++;
      $display("FAIL wrap_zero: got %0d expected 0", sample_cnt);
    end
  endtask

  task automatic test_random();
    logic exp_q[$];
    logic exp_ph;
    logic prev_hold = 1'b0;
    logic prev_phase = 1'b0;
    int since = 1000;
    int zsh = 0;
    int bad = 0;
    bit acc;
    bit ended = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i < 2500) begin
        step($urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0);
      end else begin
        step(0, 0, 0, 1);
      end
      if (sample_cnt !== CW'(exp_cnt)) bad++;
      acc = in_valid && in_ready;
      if (in_ready && exp_q.size() != 0) bad++;
      if (acc) begin
        if (!dl_shift || dl_zero) bad++;
        bump_cnt();
        exp_q.push_back(1'b0);
        if (!bypass) exp_q.push_back(1'b1);
      end else if (dl_shift) begin
        if (!dl_zero) bad++;
        zsh++;
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
      end
      since = dl_shift ? 0 : since + 1;
      if (since <= int'(DPL) && out_valid) bad++;
      if (since == int'(DPL + 1) && !out_valid) bad++;
      if (prev_hold && (!out_valid || phase !== prev_phase)) bad++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          bad++;
        end else begin
          exp_ph = exp_q.pop_front();
          if (phase !== exp_ph) bad++;
        end
      end
      prev_hold  = out_valid && !out_ready;
      prev_phase = phase;
      if (i >= 2500 && !busy && in_ready) begin ended = 1; break; end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random_model: got %0d rule violations expected 0", bad);
    end
    checks++;
    if (!ended || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain: got ended=%0d pending_outputs=%0d expected 1 0", ended, exp_q.size());
    end
    checks++;
    if ((zsh % int'(FL)) != 0) begin
      errors++;
      $display("FAIL random_flush_len: got %0d zero shifts expected a multiple of %0d", zsh, FL);
    end
  endtask

  initial begin
    reset = 1'b1; rst_next = 1'b1;
    in_valid = 1'b0; bypass = 1'b0; flush = 1'b0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_bypass();
    test_flush_idle();
    test_flush_collide();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
